// File: rtl/parallel_to_serial_stream.sv
// Parallel-to-serial stream slicer: takes a P_WIDTH word on the input
// handshake and emits up to P_WIDTH/S_WIDTH beats of S_WIDTH bits on the
// output handshake, with per-word beat count and zero-bubble word chaining.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid and ready are both high. Once out_valid is high, out_data and
// out_last stay stable until the beat is taken; valid is never withdrawn.
// in_ready depends combinationally on out_ready so that a new word can be
// taken on the same edge as the last beat of the current one.
module parallel_to_serial_stream #(
  parameter int P_WIDTH   = 24,
  parameter int S_WIDTH   = 8,
  parameter int MSB_FIRST = 1,
  localparam int BEATS    = P_WIDTH / S_WIDTH,
  localparam int LEN_W    = (BEATS < 1) ? 1 : $clog2(BEATS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0]   in_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [S_WIDTH-1:0] out_data,
  output logic               out_last,
  output logic               busy
);

  if ((P_WIDTH % S_WIDTH) != 0 || S_WIDTH > P_WIDTH) begin : g_param_check
    $error("parallel_to_serial_stream: P_WIDTH must be a non-zero multiple of S_WIDTH");
  end

  localparam logic [LEN_W-1:0] BEATS_L = LEN_W'(BEATS);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [P_WIDTH-1:0] shreg;      // slices not yet presented, next one at the head
  logic [LEN_W-1:0]   beat_cnt;   // index of the beat currently on out_data
  logic [LEN_W-1:0]   len_q;      // effective beat count of the held word
  logic [LEN_W-1:0]   eff_len;
  logic [S_WIDTH-1:0] in_head, sh_head;
  logic [P_WIDTH-1:0] in_rest, sh_rest;
  logic               take, take_last, accept;

  assign take      = out_valid & out_ready;
  assign take_last = take & out_last;
  assign in_ready  = (state == IDLE) | take_last;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);

  // Clamp the requested length: 0 or anything above BEATS means a full word.
  always_comb begin
    eff_len = in_len;
    if (in_len == '0 || in_len > BEATS_L) eff_len = BEATS_L;
  end

  // Slice selection: head is the next beat, rest moves the following slice to the head.
  always_comb begin
    in_head = '0;
    in_rest = '0;
    sh_head = '0;
    sh_rest = '0;
    if (MSB_FIRST != 0) begin
      in_head = in_data[P_WIDTH-1 -: S_WIDTH];
      in_rest = in_data << S_WIDTH;
      sh_head = shreg[P_WIDTH-1 -: S_WIDTH];
      sh_rest = shreg << S_WIDTH;
    end else begin
      in_head = in_data[S_WIDTH-1:0];
      in_rest = in_data >> S_WIDTH;
      sh_head = shreg[S_WIDTH-1:0];
      sh_rest = shreg >> S_WIDTH;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a word arriving on the last-beat edge keeps us in SHIFT.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (accept)         state_nxt = SHIFT;
        else if (take_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load first slice on accept, step on each taken beat, zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      out_data <= in_head;
      shreg    <= in_rest;
      beat_cnt <= '0;
      len_q    <= eff_len;
      out_last <= (eff_len == ONE);
    end else if (take_last) begin
      out_data <= '0;
      out_last <= 1'b0;
      beat_cnt <= '0;
    end else if (take) begin
      out_data <= sh_head;
      shreg    <= sh_rest;
      beat_cnt <= beat_cnt + ONE;
      out_last <= ((beat_cnt + ONE) == (len_q - ONE));
    end
  end

endmodule
